fifo_buffer: RTL and testbench
==============================

FIFO_BUFFER -- requirements
Module: fifo_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 6, meaning storage entries; legal range 2..7 so that the 3-bit count holds every value.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit, meaning push request.
REQ-006 SHALL have port wr_data, input, DATA_W bits, meaning push payload.
REQ-007 SHALL have port rd_en, input, 1 bit, meaning pop request.
REQ-008 SHALL have port rd_data, output, DATA_W bits, meaning registered pop payload.
REQ-009 SHALL have port rd_valid, output, 1 bit, meaning rd_data holds a popped word this cycle.
REQ-010 SHALL have port full, output, 1 bit, meaning count == DEPTH.
REQ-011 SHALL have port empty, output, 1 bit, meaning count == 0.
REQ-012 SHALL have port number_of_current_entries, output, 3 bits, meaning occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow, output, 1 bit, meaning one-cycle pulse on a rejected push.
REQ-014 SHALL have port underflow, output, 1 bit, meaning one-cycle pulse on a rejected pop.

Function
REQ-015 SHALL accept a push when wr_en=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-016 SHALL accept a pop when rd_en=1 and empty=0; a pop on empty SHALL NOT be accepted even with a simultaneous push.
REQ-017 SHALL write the accepted push into mem[wr_ptr] and advance wr_ptr by one.
REQ-018 SHALL advance rd_ptr by one on an accepted pop, and load rd_data from mem[rd_ptr] on the next clock edge, with rd_valid=1 for exactly that one cycle (1-cycle read latency).
REQ-019 SHALL hold rd_data at its last value when rd_valid=0.
REQ-020 SHALL wrap each pointer from DEPTH-1 to 0, not at a power of two.
REQ-021 SHALL update the count +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-022 SHALL register full, empty and number_of_current_entries, and keep them consistent with the count in every cycle.
REQ-023 SHALL pulse overflow for one cycle, registered, when wr_en=1 is rejected, leaving the state unchanged.
REQ-024 SHALL pulse underflow for one cycle, registered, when rd_en=1 is rejected, leaving the state unchanged.
REQ-025 SHALL produce no X on any output after the first reset cycle, regardless of memory contents.

Reset
REQ-026 SHALL, when rst=1 is sampled, clear wr_ptr, rd_ptr and count to 0, set empty=1, full=0, rd_valid=0, overflow=0, underflow=0 and rd_data=0.
REQ-027 SHALL let rst take priority over simultaneous wr_en or rd_en, discarding in-flight pushes and pops; the memory array SHALL NOT be reset.
REQ-028 SHALL accept a push in the first cycle after rst deasserts.

Structure
REQ-029 SHALL take FIFO_DEPTH (6) and CNT_W (3) from shared package fifo_pkg, which the FIFO checker also imports.
REQ-030 SHALL implement the mod-DEPTH pointer as sub-module fifo_ptr (inputs clk, rst, inc; output ptr), instantiated once for write and once for read.

Verification
REQ-031 SHALL verify: after reset, push 0x11..0x66 on six cycles -> count 1..6, full=1 on the cycle after the sixth push, and a seventh push gives overflow=1 with count=6.
REQ-032 SHALL verify: from full, six pops -> rd_data 0x11..0x66 in order, each one cycle after its rd_en, with empty=1 after the sixth pop and a seventh pop giving underflow=1.
REQ-033 SHALL verify: while full, push 0x77 and pop together -> count stays 6, the pop returns 0x11, and 0x77 is returned last.
REQ-034 SHALL verify: while empty, push 0xA5 and pop together -> underflow=1, count=1, rd_valid=0, and a following pop returns 0xA5.
REQ-035 SHALL verify: 20 alternating push/pop cycles with data 0..19 -> output order 0..19 across pointer wrap at 5->0.
REQ-036 SHALL verify: assert rst with count=4 while wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, and the checker covers entry counts 0 through 6.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, imported by the RTL and by the checker.
package fifo_pkg;

    localparam int FIFO_DEPTH = 6;
    localparam int CNT_W      = 3;

    // Encoding matches {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Increment with wrap at depth-1. The wrap is not at a power of two.
    function automatic logic [CNT_W-1:0] ptr_next(input logic [CNT_W-1:0] p,
                                                  input int depth);
        return (p == CNT_W'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Mod-DEPTH pointer. One instance is used as the write pointer and one as the read pointer.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] ptr
);

    logic [CNT_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= ptr_next(r_ptr, DEPTH);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FIFO with a non-power-of-two depth, registered status flags,
// a 1-cycle registered read, and one-cycle overflow and underflow pulses.
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  number_of_current_entries,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_pop_ok;
    logic              w_push_ok;
    logic [CNT_W-1:0]  w_wr_ptr;
    logic [CNT_W-1:0]  w_rd_ptr;
    logic [CNT_W-1:0]  w_count_nxt;
    fifo_op_e          w_op;

    // A pop on an empty FIFO is rejected even when a push arrives in the same cycle.
    // A push on a full FIFO goes through only when a pop frees a slot in the same cycle.
    assign w_pop_ok  = rd_en && !r_empty;
    assign w_push_ok = wr_en && (!r_full || w_pop_ok);
    assign w_op      = fifo_op_e'({w_push_ok, w_pop_ok});

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_push_ok),
        .ptr (w_wr_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_pop_ok),
        .ptr (w_rd_ptr)
    );

    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: w_count_nxt = r_count + 1'b1;
            OP_POP:  w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // The storage array has no reset. rd_data only ever samples entries that were written.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[w_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty     <= (w_count_nxt == '0);
            r_overflow  <= wr_en && !w_push_ok;
            r_underflow <= rd_en && !w_pop_ok;
        end
    end

    // When the FIFO is full, wr_ptr == rd_ptr, so a same-cycle push and pop reads
    // the old word before the new one lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_pop_ok) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end
        end
    end

    assign rd_data                   = r_rd_data;
    assign rd_valid                  = r_rd_valid;
    assign full                      = r_full;
    assign empty                     = r_empty;
    assign number_of_current_entries = r_count;
    assign overflow                  = r_overflow;
    assign underflow                 = r_underflow;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed checker for fifo_buffer. A reference queue holds the expected pop data,
// and a small occupancy model predicts the flags and pulses for every cycle.
module tb_fifo_buffer;
    import fifo_pkg::*;

    localparam int DW = 8;
    localparam int D  = FIFO_DEPTH;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [DW-1:0]    wr_data;
    logic             rd_en;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] number_of_current_entries;
    logic             overflow;
    logic             underflow;

    fifo_buffer #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .wr_en                     (wr_en),
        .wr_data                   (wr_data),
        .rd_en                     (rd_en),
        .rd_data                   (rd_data),
        .rd_valid                  (rd_valid),
        .full                      (full),
        .empty                     (empty),
        .number_of_current_entries (number_of_current_entries),
        .overflow                  (overflow),
        .underflow                 (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [DW-1:0] sb_q[$];
    int           m_cnt = 0;
    logic [DW-1:0] m_last = '0;
    logic [D:0]   cov = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic e_vld, input logic e_ovf,
                             input logic e_unf);
        chk({tag, ".count"},    32'(number_of_current_entries), 32'(m_cnt));
        chk({tag, ".full"},     32'(full),      32'(m_cnt == D));
        chk({tag, ".empty"},    32'(empty),     32'(m_cnt == 0));
        chk({tag, ".rd_valid"}, 32'(rd_valid),  32'(e_vld));
        chk({tag, ".rd_data"},  32'(rd_data),   32'(m_last));
        chk({tag, ".overflow"}, 32'(overflow),  32'(e_ovf));
        chk({tag, ".underflow"},32'(underflow), 32'(e_unf));
        cov[m_cnt] = 1'b1;
    endtask

    // Drive one cycle, let it clock, then compare the outputs against the model.
    task automatic cyc(input string tag, input logic we, input logic [DW-1:0] wd,
                       input logic re);
        logic pop_ok, push_ok;
        rst     = 1'b0;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        pop_ok  = re && (m_cnt > 0);
        push_ok = we && ((m_cnt < D) || pop_ok);
        @(posedge clk);
        #1;
        if (pop_ok)  m_last = sb_q.pop_front();
        if (push_ok) sb_q.push_back(wd);
        m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk_state(tag, pop_ok, we && !push_ok, re && !pop_ok);
    endtask

    task automatic do_reset(input string tag, input logic we, input logic re);
        rst     = 1'b1;
        wr_en   = we;
        wr_data = 8'hEE;
        rd_en   = re;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        sb_q.delete();
        m_cnt  = 0;
        m_last = '0;
        chk_state(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        @(posedge clk);
        #1;
        do_reset("rst0", 1'b0, 1'b0);

        // Fill the FIFO to full, then push once more to get an overflow.
        for (int i = 1; i <= D; i++) cyc($sformatf("fill%0d", i), 1'b1, DW'(i * 8'h11), 1'b0);
        cyc("ovf", 1'b1, 8'h99, 1'b0);

        // Drain in order, then pop once more to get an underflow.
        for (int i = 1; i <= D; i++) cyc($sformatf("drain%0d", i), 1'b0, '0, 1'b1);
        cyc("unf", 1'b0, '0, 1'b1);

        // Push and pop together while full: the count stays at 6.
        for (int i = 1; i <= D; i++) cyc($sformatf("refill%0d", i), 1'b1, DW'(i * 8'h11), 1'b0);
        cyc("fullboth", 1'b1, 8'h77, 1'b1);
        chk("fullboth.pop11", 32'(rd_data), 32'h11);
        for (int i = 1; i <= D; i++) cyc($sformatf("drain2_%0d", i), 1'b0, '0, 1'b1);
        chk("last77", 32'(rd_data), 32'h77);

        // Push and pop together while empty: the pop is rejected.
        cyc("emptyboth", 1'b1, 8'hA5, 1'b1);
        cyc("popA5", 1'b0, '0, 1'b1);
        chk("popA5.data", 32'(rd_data), 32'hA5);

        // Alternate push and pop so that both pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("alt_w%0d", i), 1'b1, DW'(i), 1'b0);
            cyc($sformatf("alt_r%0d", i), 1'b0, '0, 1'b1);
            chk($sformatf("alt_d%0d", i), 32'(rd_data), 32'(i));
        end

        // Reset with 4 entries held while wr_en and rd_en are both active.
        for (int i = 0; i < 4; i++) cyc($sformatf("pre%0d", i), 1'b1, DW'(8'hC0 + i), 1'b0);
        do_reset("rstbusy", 1'b1, 1'b1);
        cyc("postrst_push", 1'b1, 8'h3C, 1'b0);
        cyc("postrst_pop", 1'b0, '0, 1'b1);
        chk("postrst.data", 32'(rd_data), 32'h3C);

        for (int k = 0; k <= D; k++) chk($sformatf("cov_cnt%0d", k), 32'(cov[k]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
